// File: rtl/dso_wave_reader.sv
// rtl/dso_wave_reader.sv - waveform RAM read engine streaming (x, y) points; DSO_WAVE_READER_INVERT_EN flips y
module dso_wave_reader #(
    parameter int WAVE_POINTS = 300,
    parameter int RD_LAT      = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       frame_start,
    output logic       ram_rd_en,
    output logic [9:0] wave_rd_addr,
    input  logic [7:0] wave_rd_data,
    output logic       ram_rd_over,
    output logic       pt_valid,
    input  logic       pt_ready,
    output logic [9:0] pt_x,
    output logic [7:0] pt_y,
    output logic       busy,
    output logic       frame_done
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [9:0] LAST = 10'(WAVE_POINTS - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, OVER} state_t;

    state_t          state, state_nxt;
    logic [RD_LAT-1:0] lat_sr;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   inflight;
    logic [CW:0]     used;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [7:0]      head_y;
    logic [9:0]      rd_addr, x_cnt;
    logic            pop, push, start;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

`ifdef DSO_WAVE_READER_INVERT_EN
    assign head_y = 8'd255 - mem[rd_ptr];
`else
    assign head_y = mem[rd_ptr];
`endif

    assign push         = lat_sr[RD_LAT-1];
    assign start        = (state == IDLE) && frame_start;
    assign wave_rd_addr = rd_addr;
    assign pt_x         = x_cnt;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(lat_sr[i]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = READ;
            READ:    if (ram_rd_en && (rd_addr == LAST)) state_nxt = DRAIN;
            DRAIN:   if (pop && (x_cnt == LAST)) state_nxt = OVER;
            default: state_nxt = IDLE;
        endcase
    end

    // A pop in the same cycle frees its credit, which keeps issue bubble-free
    always_comb begin
        busy        = (state != IDLE);
        ram_rd_over = (state == OVER);
        frame_done  = (state == OVER);
        pt_valid    = (fifo_count != '0);
        pt_y        = pt_valid ? head_y : 8'd0;
        pop         = pt_valid && pt_ready;
        used        = (CW+1)'(fifo_count) + (CW+1)'(inflight) - (CW+1)'(pop);
        ram_rd_en   = (state == READ) && (used < (CW+1)'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_sr     <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rd_addr    <= '0;
            x_cnt      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            lat_sr <= (lat_sr << 1) | RD_LAT'(ram_rd_en);
            if (push) begin
                mem[wr_ptr] <= wave_rd_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (start) begin
                rd_addr <= '0;
            end else if (ram_rd_en) begin
                rd_addr <= (rd_addr == LAST) ? '0 : rd_addr + 10'd1;
            end
            if (start) begin
                x_cnt <= '0;
            end else if (pop) begin
                x_cnt <= (x_cnt == LAST) ? '0 : x_cnt + 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_dso_wave_reader.sv
// tb/tb_dso_wave_reader.sv - bench for dso_wave_reader at RD_LAT=1 and RD_LAT=3
module tb_dso_wave_reader;

    localparam int NPTS  = 300;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       frame_start;
    logic       pt_ready;
    logic       en    [2];
    logic [9:0] addr  [2];
    logic [7:0] rdata [2];
    logic       over  [2];
    logic       valid [2];
    logic [9:0] x     [2];
    logic [7:0] y     [2];
    logic       busy  [2];
    logic       done  [2];

    always #5 clk = ~clk;

    dso_wave_reader #(.WAVE_POINTS(NPTS), .RD_LAT(1), .FIFO_DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .rstn(rstn), .frame_start(frame_start),
        .ram_rd_en(en[0]), .wave_rd_addr(addr[0]), .wave_rd_data(rdata[0]),
        .ram_rd_over(over[0]), .pt_valid(valid[0]), .pt_ready(pt_ready),
        .pt_x(x[0]), .pt_y(y[0]), .busy(busy[0]), .frame_done(done[0])
    );

    dso_wave_reader #(.WAVE_POINTS(NPTS), .RD_LAT(3), .FIFO_DEPTH(DEPTH)) u_dut3 (
        .clk(clk), .rstn(rstn), .frame_start(frame_start),
        .ram_rd_en(en[1]), .wave_rd_addr(addr[1]), .wave_rd_data(rdata[1]),
        .ram_rd_over(over[1]), .pt_valid(valid[1]), .pt_ready(pt_ready),
        .pt_x(x[1]), .pt_y(y[1]), .busy(busy[1]), .frame_done(done[1])
    );

    // RAM contents: identity for the first instance, a scrambled ramp for the second
    function automatic logic [7:0] ram_val(input int id, input int a);
        int v;
        v = (id == 0) ? a : (a * 37 + 11);
        return 8'(v);
    endfunction

    function automatic int exp_y(input int id, input int k);
`ifdef DSO_WAVE_READER_INVERT_EN
        return 255 - int'(ram_val(id, k));
`else
        return int'(ram_val(id, k));
`endif
    endfunction

    int cyc = 0;
    int pipe_a [2][3];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int id = 0; id < 2; id++) begin
            pipe_a[id][2] <= pipe_a[id][1];
            pipe_a[id][1] <= pipe_a[id][0];
            pipe_a[id][0] <= en[id] ? int'(addr[id]) : 999;
        end
    end

    assign rdata[0] = ram_val(0, pipe_a[0][0]);
    assign rdata[1] = ram_val(1, pipe_a[1][2]);

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Model state: outstanding reads and transfers per frame, frame lifecycle
    int issued [2];
    int got [2];
    bit mbusy [2];
    bit over_due [2];
    int over_total [2];
    int over_cyc [2];
    int first_en [2];
    int first_val [2];
    int issue_cyc [2][NPTS];
    bit prev_stall [2];
    int prev_x [2];
    int prev_y [2];
    int dut_issued [2];
    int dut_xfer [2];

    task automatic model_step(input int id);
        int  lat;
        bit  exp_valid, exp_en, xfer, was_over, start;
        string s;
        lat = (id == 0) ? 1 : 3;
        s = $sformatf("i%0d", id);
        if (!rstn) begin
            chk({s, "_rst_en"}, int'(en[id]), 0);
            chk({s, "_rst_addr"}, int'(addr[id]), 0);
            chk({s, "_rst_over"}, int'(over[id]), 0);
            chk({s, "_rst_valid"}, int'(valid[id]), 0);
            chk({s, "_rst_x"}, int'(x[id]), 0);
            chk({s, "_rst_y"}, int'(y[id]), 0);
            chk({s, "_rst_busy"}, int'(busy[id]), 0);
            chk({s, "_rst_done"}, int'(done[id]), 0);
            issued[id] = 0; got[id] = 0; mbusy[id] = 0; over_due[id] = 0;
            prev_stall[id] = 0; dut_issued[id] = 0; dut_xfer[id] = 0;
            return;
        end
        start     = frame_start && !mbusy[id];
        was_over  = over_due[id];
        exp_valid = (got[id] < issued[id]) && (cyc >= issue_cyc[id][got[id]] + lat + 1);
        exp_en    = mbusy[id] && (issued[id] < NPTS) &&
                    ((issued[id] - got[id] - int'(exp_valid && pt_ready)) < DEPTH);
        xfer      = exp_valid && pt_ready;

        chk({s, "_valid"}, int'(valid[id]), int'(exp_valid));
        chk({s, "_rd_en"}, int'(en[id]), int'(exp_en));
        chk({s, "_busy"}, int'(busy[id]), int'(mbusy[id]));
        chk({s, "_over"}, int'(over[id]), int'(was_over));
        chk({s, "_done"}, int'(done[id]), int'(was_over));
        if (prev_stall[id]) begin
            chk({s, "_stall_x"}, int'(x[id]), prev_x[id]);
            chk({s, "_stall_y"}, int'(y[id]), prev_y[id]);
        end
        if (exp_valid) begin
            chk({s, "_pt_x"}, int'(x[id]), got[id]);
            chk({s, "_pt_y"}, int'(y[id]), exp_y(id, got[id]));
        end
        if (en[id]) begin
            dut_issued[id]++;
            chk({s, "_rd_addr"}, int'(addr[id]), issued[id]);
        end
        if (valid[id] && pt_ready) dut_xfer[id]++;

        if (exp_en) begin
            if (issued[id] == 0) first_en[id] = cyc;
            issue_cyc[id][issued[id]] = cyc;
            issued[id]++;
        end
        if (exp_valid && got[id] == 0 && first_val[id] < 0) first_val[id] = cyc;
        if (was_over) begin
            over_total[id]++;
            over_cyc[id] = cyc;
            mbusy[id]    = 0;
            over_due[id] = 0;
        end
        if (xfer) begin
            got[id]++;
            if (got[id] == NPTS) over_due[id] = 1;
        end
        if (start) begin
            mbusy[id] = 1; issued[id] = 0; got[id] = 0;
            first_en[id] = -1; first_val[id] = -1;
            dut_issued[id] = 0; dut_xfer[id] = 0;
        end
        prev_stall[id] = exp_valid && !pt_ready;
        prev_x[id] = int'(x[id]);
        prev_y[id] = int'(y[id]);
    endtask

    always @(negedge clk) begin
        for (int id = 0; id < 2; id++) model_step(id);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((mbusy[0] || mbusy[1]) && n < limit) begin
            tick();
            n++;
        end
        chk("idle_reached", int'(!mbusy[0] && !mbusy[1]), 1);
    endtask

    initial begin
        rstn = 1'b0;
        frame_start = 1'b0;
        pt_ready = 1'b1;
        repeat (3) tick();
        chk("reset_valid", int'(valid[0]), 0);
        chk("reset_busy", int'(busy[1]), 0);
        rstn = 1'b1;
        tick();

        // Full-rate frame
        start_frame();
        wait_idle(400);
        chk("a_over_delay_lat1", over_cyc[0] - first_en[0], 302);
        chk("a_over_delay_lat3", over_cyc[1] - first_en[1], 304);
        chk("a_first_valid_lat1", first_val[0] - first_en[0], 2);
        chk("a_first_valid_lat3", first_val[1] - first_en[1], 4);
        chk("a_points_lat1", got[0], 300);
        chk("a_points_lat3", got[1], 300);
        chk("a_over_count_lat1", over_total[0], 1);
        chk("a_over_count_lat3", over_total[1], 1);

        // Toggling ready, then a long stall
        start_frame();
        for (int i = 0; i < 60; i++) begin
            pt_ready = (i % 2) == 0;
            tick();
        end
        pt_ready = 1'b0;
        repeat (20) tick();
        chk("b_outstanding_lat1", dut_issued[0] - dut_xfer[0], 4);
        chk("b_outstanding_lat3", dut_issued[1] - dut_xfer[1], 4);
        chk("b_rd_en_stalled", int'(en[0]), 0);
        pt_ready = 1'b1;
        wait_idle(700);
        chk("b_points", got[0], 300);
        chk("b_over_count", over_total[1], 2);

        // Stray frame_start mid-frame, then restart right after OVER
        start_frame();
        for (int n = 0; n < 300 && got[0] < 100; n++) tick();
        start_frame();
        for (int n = 0; n < 400; n++) begin
            tick();
            if (over[0]) break;
        end
        chk("c_over_seen", int'(over[0]), 1);
        tick();
        start_frame();
        chk("c_over_count_before_restart", over_total[0], 3);
        wait_idle(700);
        chk("c_points", got[0], 300);
        chk("c_over_count_lat1", over_total[0], 4);
        chk("c_over_count_lat3", over_total[1], 3);

        // Reset at point 150
        start_frame();
        for (int n = 0; n < 300 && got[0] < 150; n++) tick();
        rstn = 1'b0;
        #1;
        chk("d_async_valid", int'(valid[0]), 0);
        chk("d_async_busy", int'(busy[1]), 0);
        tick();
        rstn = 1'b1;
        tick();
        chk("d_no_over_lat1", over_total[0], 4);
        chk("d_no_over_lat3", over_total[1], 3);
        start_frame();
        wait_idle(400);
        chk("d_points", got[0], 300);
        chk("d_over_count", over_total[0], 5);

        // Ready low for the whole frame
        pt_ready = 1'b0;
        start_frame();
        repeat (60) tick();
        chk("e_reads_lat1", dut_issued[0], 4);
        chk("e_reads_lat3", dut_issued[1], 4);
        chk("e_busy", int'(busy[0]), 1);
        chk("e_no_over", over_total[0], 5);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dso_wave_reader.md
# dso_wave_reader

Read-side engine for the oscilloscope's captured-waveform RAM. On each frame request it fetches the 300 stored points through the `ram_rd_en` / `wave_rd_addr` / `wave_rd_data` port and buffers them in a small credit-controlled FIFO. It then streams each point as an (x, y) pair over a valid/ready handshake to the display renderer, and pulses `ram_rd_over` to hand the RAM back to the capture side so it can re-arm.

## Interface
- `WAVE_POINTS`, 300: points per frame; addresses 0 .. WAVE_POINTS-1.
- `RD_LAT`, 1: cycles from a `ram_rd_en` cycle to valid `wave_rd_data`; legal range 1..3.
- `FIFO_DEPTH`, 4: point buffer entries; must be >= RD_LAT+1.
- `clk` in 1: single clock; drives the RAM read side (`ram_rd_clk`) as well.
- `rstn` in 1: reset, asynchronous, active-low.
- `frame_start` in 1: one-cycle request to fetch a frame.
- `ram_rd_en` out 1: RAM read strobe.
- `wave_rd_addr` out 10: RAM read address.
- `wave_rd_data` in 8: RAM read data, valid RD_LAT cycles after the strobe.
- `ram_rd_over` out 1: one-cycle pulse; the frame has been fully consumed.
- `pt_valid` out 1: output point valid.
- `pt_ready` in 1: downstream accepts the point.
- `pt_x` out 10: point index 0 .. WAVE_POINTS-1.
- `pt_y` out 8: point amplitude.
- `busy` out 1: high from READ until return to IDLE.
- `frame_done` out 1: one-cycle pulse, coincident with `ram_rd_over`.

## Operation
- FSM with four states: IDLE, READ, DRAIN, OVER.
  - IDLE → READ when `frame_start`=1. The read address and output index clear to 0.
  - READ → DRAIN in the cycle the read of address WAVE_POINTS-1 is issued.
  - DRAIN → OVER in the cycle the point with `pt_x`=WAVE_POINTS-1 is accepted.
  - OVER → IDLE unconditionally after one cycle.
- `frame_start` is ignored outside IDLE. It is not queued.
- Read issue rule: `ram_rd_en` = (state==READ) && (fifo_count + inflight < FIFO_DEPTH). The count includes a pop occurring in the same cycle.
  - `wave_rd_addr` increments after each issued read.
  - `ram_rd_en` is combinational from registered state.
- Inflight tracking:
  - A RD_LAT-stage valid shift register tracks issued reads.
  - Data is written to the FIFO in the cycle its shift bit exits.
  - The FIFO never overflows by construction. An overflow is a design error and is checked by the bench.
- Output:
  - `pt_valid` = FIFO non-empty.
  - `pt_y` = FIFO head, mapped per Configuration.
  - `pt_x` = accepted-point counter.
  - A transfer occurs on `pt_valid && pt_ready`. The FIFO pops and `pt_x` increments in that cycle.
- `pt_x`, `pt_y` and `pt_valid` stay stable while `pt_valid && !pt_ready`.
- `busy` = state != IDLE.

## Timing
- Reset values: `ram_rd_en`=0, `wave_rd_addr`=0, `ram_rd_over`=0, `pt_valid`=0, `pt_x`=0, `pt_y`=0, `busy`=0, `frame_done`=0. The FIFO is empty, inflight is 0, and the FSM is in IDLE.
- `frame_start` sampled high at edge E: READ begins at E+1, and the first `ram_rd_en` (addr 0) occurs in that cycle.
- The first `pt_valid` asserts RD_LAT+1 cycles after the first `ram_rd_en` cycle.
- With `pt_ready` held high, one point transfers per cycle. Reads issue on WAVE_POINTS consecutive cycles with no bubbles.
- `ram_rd_over` and `frame_done` are high exactly in the OVER cycle, the cycle after the last transfer.
- Frame duration with `pt_ready`=1: `ram_rd_over` pulses WAVE_POINTS+RD_LAT+1 cycles after the first `ram_rd_en`.
- Backpressure: when the FIFO holds FIFO_DEPTH-inflight entries, issue stalls and `wave_rd_addr` holds. Issue resumes in the cycle a pop frees a credit.
- Async reset mid-frame: all state returns to reset values immediately. No `ram_rd_over` is generated and no partial frame is resumed.
- Arithmetic: address and index counters are 10-bit and never exceed WAVE_POINTS-1; no wrap occurs within a frame.

## Configuration
- `DSO_WAVE_READER_INVERT_EN` defined: `pt_y` = 255 - sample, i.e. screen coordinates with the top row at 0.
- Not defined: `pt_y` = sample unchanged.
- All timing is identical in both builds.

## Test plan
- Reset, then `frame_start` with `pt_ready`=1, RAM[i]=i[7:0], RD_LAT=1 → 300 consecutive transfers with `pt_x`=0..299 and `pt_y`=i[7:0] (or 255-i[7:0] with the macro). `ram_rd_over` pulses once, 302 cycles after the first `ram_rd_en`.
- `pt_ready` toggling 1010…, then held low for 20 cycles mid-frame → no lost or duplicated points, `pt_x`/`pt_y` stable while stalled, and `ram_rd_en` stalls after FIFO_DEPTH outstanding points.
- RD_LAT=3, FIFO_DEPTH=4, `pt_ready`=1 → no throughput bubbles, no FIFO overflow, first `pt_valid` 4 cycles after the first `ram_rd_en`.
- `frame_start` pulsed again at point 100 → ignored; exactly 300 points and one `ram_rd_over`. A new `frame_start` in the cycle after OVER starts a fresh frame at addr 0.
- `rstn` asserted at point 150 → all outputs 0 immediately and no `ram_rd_over`. A subsequent `frame_start` yields a complete frame from `pt_x`=0.
- `pt_ready`=0 for the entire frame → `busy` stays 1, `ram_rd_en` pulses exactly FIFO_DEPTH times, then the block holds indefinitely.
